// File: rtl/testio_pkg.sv
// rtl/testio_pkg.sv - shared test-link state codes, frame field lengths and line idle value
package testio_pkg;

    localparam int   ADDR_BITS = 32;
    localparam int   DATA_BITS = 32;
    localparam int   CNT_W     = 6;
    localparam logic IDLE_LINE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        RX_HDR,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        BUS,
        TX_TURN,
        TX_START,
        TX_ACK,
        TX_PAR,
        TX_DATA,
        TX_STOP
    } testio_state_e;

    // Bit-counter load value on entry to a state; the state exits when it reaches 0.
    function automatic logic [CNT_W-1:0] state_len(input testio_state_e s);
        case (s)
            RX_HDR:           return CNT_W'(ADDR_BITS);
            RX_DATA, TX_DATA: return CNT_W'(DATA_BITS - 1);
            default:          return '0;
        endcase
    endfunction

endpackage

// File: rtl/testio_slave_shifter.sv
// rtl/testio_slave_shifter.sv - frame shift register, down-counting bit counter and running parity
module testio_slave_shifter
    import testio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 shift_i,
    input  logic                 bit_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] load_data_i,
    input  logic                 cnt_load_i,
    input  logic [CNT_W-1:0]     cnt_val_i,
    output logic [DATA_BITS-1:0] word_o,
    output logic                 cnt_zero_o,
    output logic                 parity_o
);

    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;

    always_comb begin
        sh_d  = sh_q;
        par_d = par_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            par_d = 1'b0;
        end
        if (load_i) begin
            sh_d = load_data_i;
        end else if (shift_i) begin
            sh_d  = {sh_q[DATA_BITS-2:0], bit_i};
            par_d = par_q ^ bit_i;
        end
        if (cnt_load_i) begin
            cnt_d = cnt_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    assign word_o     = sh_q;
    assign cnt_zero_o = (cnt_q == '0);
    assign parity_o   = par_q;

endmodule

// File: rtl/testio_slave_top.sv
// rtl/testio_slave_top.sv - test-link slave: frame receive, Wishbone access, response transmit
// Optional bus timeout is built when TESTIO_SLAVE_TIMEOUT_EN is defined.
module testio_slave_top
    import testio_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ti_i,
    output logic                 ti_o,
    output logic                 ti_oen,
    output logic                 testio_wb_cyc_o,
    output logic                 testio_wb_stb_o,
    output logic                 testio_wb_we_o,
    output logic [BUS_WIDTH-1:0] testio_wb_addr_o,
    output logic [BUS_WIDTH-1:0] testio_wb_wdata_o,
    output logic [3:0]           testio_wb_sel_o,
    input  logic                 wb_testio_ack_i,
    input  logic [BUS_WIDTH-1:0] wb_testio_rdata_i
);

    testio_state_e        state_q, state_d;
    logic                 ti_q;
    logic                 armed_q;
    logic                 rw_q, rw_d;
    logic                 ack_q, ack_d;
    logic                 pok_q, pok_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] word;
    logic                 cnt_zero, par_run;
    logic                 shift, sh_load, clr;
    logic                 ti_o_d, ti_oen_d;
    logic                 tmo_hit;

`ifdef TESTIO_SLAVE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != BUS) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    // Bus waits indefinitely for ack.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    testio_slave_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .shift_i     (shift),
        .bit_i       (ti_q),
        .load_i      (sh_load),
        .load_data_i (DATA_BITS'(wb_testio_rdata_i)),
        .cnt_load_i  (state_d != state_q),
        .cnt_val_i   (state_len(state_d)),
        .word_o      (word),
        .cnt_zero_o  (cnt_zero),
        .parity_o    (par_run)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        pok_d    = pok_q;
        addr_d   = addr_q;
        shift    = 1'b0;
        sh_load  = 1'b0;
        clr      = 1'b0;
        ti_o_d   = IDLE_LINE;
        ti_oen_d = 1'b1;
        case (state_q)
            IDLE: begin
                // armed_q keeps the tail of our own turnaround from looking like a start bit
                if (armed_q && !ti_q) begin
                    state_d = RX_HDR;
                    clr     = 1'b1;
                    ack_d   = 1'b0;
                    pok_d   = 1'b0;
                end
            end
            RX_HDR: begin
                shift = 1'b1;
                if (cnt_zero) begin
                    // rw has just reached the top of the word as a0 arrives
                    rw_d    = word[DATA_BITS-1];
                    addr_d  = {word[DATA_BITS-2:0], ti_q};
                    state_d = word[DATA_BITS-1] ? RX_DATA : RX_PAR;
                end
            end
            RX_DATA: begin
                shift = 1'b1;
                if (cnt_zero) begin
                    state_d = RX_PAR;
                end
            end
            RX_PAR: begin
                pok_d   = (par_run == ti_q);
                state_d = RX_STOP;
            end
            RX_STOP: begin
                state_d = (pok_q && ti_q) ? BUS : TX_TURN;
            end
            BUS: begin
                if (wb_testio_ack_i) begin
                    state_d = TX_TURN;
                    ack_d   = 1'b1;
                    sh_load = 1'b1;
                end else if (tmo_hit) begin
                    state_d = TX_TURN;
                end
            end
            TX_TURN: begin
                ti_oen_d = 1'b0;
                state_d  = TX_START;
            end
            TX_START: begin
                ti_oen_d = 1'b0;
                ti_o_d   = 1'b0;
                state_d  = TX_ACK;
            end
            TX_ACK: begin
                ti_oen_d = 1'b0;
                ti_o_d   = ack_q;
                state_d  = rw_q ? TX_PAR : (ack_q ? TX_DATA : TX_STOP);
            end
            TX_PAR: begin
                ti_oen_d = 1'b0;
                ti_o_d   = pok_q;
                state_d  = TX_STOP;
            end
            TX_DATA: begin
                ti_oen_d = 1'b0;
                ti_o_d   = word[DATA_BITS-1];
                shift    = 1'b1;
                if (cnt_zero) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                ti_oen_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ti_q    <= IDLE_LINE;
            armed_q <= 1'b0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
            pok_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ti_q    <= ti_i;
            armed_q <= (state_q == IDLE);
            rw_q    <= rw_d;
            ack_q   <= ack_d;
            pok_q   <= pok_d;
            addr_q  <= addr_d;
        end
    end

    // Pad registers trail the FSM by half a cycle; reset reaches them through state_q.
    always_ff @(negedge clk) begin
        ti_o   <= ti_o_d;
        ti_oen <= ti_oen_d;
    end

    assign testio_wb_cyc_o   = (state_q == BUS);
    assign testio_wb_stb_o   = (state_q == BUS);
    assign testio_wb_we_o    = (state_q == BUS) && rw_q;
    assign testio_wb_addr_o  = BUS_WIDTH'(addr_q);
    assign testio_wb_wdata_o = BUS_WIDTH'(word);
    assign testio_wb_sel_o   = 4'hf;

endmodule
